// File: rtl/mem_lock_arbiter.sv
// Two-core shared-memory arbiter with a single hardware lock (load-lock / store-unlock).
// Latency: grant registered from IDLE, one or more BUSY cycles until mem_ack, then one RESP cycle with the ack pulse.
// Backpressure: requests wait in IDLE while ineligible or while another operation is in flight; mem_req holds until mem_ack.
module mem_lock_arbiter (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req0,
   input  logic        req1,
   input  logic [1:0]  op0,
   input  logic [1:0]  op1,
   input  logic [19:0] addr0,
   input  logic [19:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        ack0,
   output logic        ack1,
   output logic [31:0] rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [19:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        lock_held,
   output logic        lock_owner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] OP_LOAD_LOCK    = 2'b10;
   localparam logic [1:0] OP_STORE_UNLOCK = 2'b11;

   state_t      state_q;
   state_t      state_d;

   // Registered copy of the granted request; the memory side only ever sees these.
   logic        cur_core;
   logic [1:0]  cur_op;
   logic [19:0] cur_addr;
   logic [31:0] cur_wdata;
   logic [31:0] rdata_q;

   // Core preferred on the next contended grant.
   logic        rr_ptr;

   logic        elig0;
   logic        elig1;
   logic        grant_vld;
   logic        grant_core;

   // Eligibility and round-robin selection; lock ops from a non-owner are skipped while the lock is held.
   always_comb begin
      elig0      = req0 && (!op0[1] || !lock_held || (lock_owner == 1'b0));
      elig1      = req1 && (!op1[1] || !lock_held || (lock_owner == 1'b1));
      grant_vld  = elig0 || elig1;
      grant_core = 1'b0;
      if (elig0 && elig1) begin
         grant_core = rr_ptr;
      end else if (elig1) begin
         grant_core = 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and output decode; the memory port and acks are pure functions of state and registered request.
   always_comb begin
      state_d   = state_q;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      ack0      = 1'b0;
      ack1      = 1'b0;
      mem_addr  = cur_addr;
      mem_wdata = cur_wdata;
      rdata     = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            mem_req = 1'b1;
            mem_we  = cur_op[0];
            if (mem_ack) begin
               state_d = RESP;
            end
         end
         RESP: begin
            ack0    = (cur_core == 1'b0);
            ack1    = (cur_core == 1'b1);
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Request capture at grant, read-data capture and lock update at memory completion.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cur_core   <= 1'b0;
         cur_op     <= 2'b00;
         cur_addr   <= 20'h0;
         cur_wdata  <= 32'h0;
         rdata_q    <= 32'h0;
         rr_ptr     <= 1'b0;
         lock_held  <= 1'b0;
         lock_owner <= 1'b0;
      end else begin
         if ((state_q == IDLE) && grant_vld) begin
            cur_core  <= grant_core;
            cur_op    <= grant_core ? op1 : op0;
            cur_addr  <= grant_core ? addr1 : addr0;
            cur_wdata <= grant_core ? wdata1 : wdata0;
            rr_ptr    <= ~grant_core;
         end
         if ((state_q == BUSY) && mem_ack) begin
            // Stores return zero so a core never sees stale load data on its ack.
            rdata_q <= cur_op[0] ? 32'h0 : mem_rdata;
            if (cur_op == OP_LOAD_LOCK) begin
               lock_held  <= 1'b1;
               lock_owner <= cur_core;
            end else if (cur_op == OP_STORE_UNLOCK) begin
               lock_held  <= 1'b0;
            end
         end
      end
   end

endmodule

// File: doc/mem_lock_arbiter.md
MEM_LOCK_ARBITER -- requirements
Module: mem_lock_arbiter

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-003 req0 / req1  input  1  core 0 / core 1 memory request valid; held high until that core's ack.
REQ-004 op0 / op1  input  2  per-core operation: 00 load, 01 store, 10 load-lock (acquire), 11 store-unlock (release).
REQ-005 addr0 / addr1  input  20  per-core word address.
REQ-006 wdata0 / wdata1  input  32  per-core store data.
REQ-007 ack0 / ack1  output  1  one-cycle completion pulse to core 0 / core 1.
REQ-008 rdata  output  32  load data, valid only while ack0 or ack1 is high.
REQ-009 mem_req  output  1  request to the shared memory; held until mem_ack.
REQ-010 mem_we  output  1  memory write enable (1 for op 01/11).
REQ-011 mem_addr  output  20  memory address.
REQ-012 mem_wdata  output  32  memory write data.
REQ-013 mem_ack  input  1  memory completion; may assert in the first mem_req cycle or any later cycle.
REQ-014 mem_rdata  input  32  memory read data, valid while mem_ack is high.
REQ-015 lock_held  output  1  lock currently owned.
REQ-016 lock_owner  output  1  owning core index; meaningful only when lock_held is 1.

Function
REQ-017 FSM states: IDLE, BUSY, RESP; transitions only on rising clk.
REQ-018 Eligibility: load/store always eligible; load-lock and store-unlock eligible only if lock_held is 0 or lock_owner equals the requester.
REQ-019 In IDLE, an eligible request is selected; the selected core's op/addr/wdata and index are registered and the FSM moves to BUSY.
REQ-020 Arbitration is round-robin: when both cores are eligible, the core not granted last wins; the pointer updates on every grant; first grant after reset goes to core 0.
REQ-021 An ineligible request is skipped without blocking the other core; it waits in IDLE until it becomes eligible.
REQ-022 In BUSY, mem_req is 1 and mem_we/mem_addr/mem_wdata are driven from the registered request and held stable.
REQ-023 On a BUSY cycle with mem_ack=1: mem_rdata is captured, the lock is updated, and the FSM moves to RESP.
REQ-024 Lock update at mem_ack: op 10 sets lock_held=1 and lock_owner=requester; op 11 sets lock_held=0; ops 00/01 leave the lock unchanged.
REQ-025 A load-lock by the current owner keeps the lock held.
REQ-026 A store-unlock with the lock free performs the store and leaves lock_held at 0.
REQ-027 In RESP, exactly one of ack0/ack1 is 1 for one cycle, rdata carries the captured data (0 for stores), and the FSM returns to IDLE.
REQ-028 Minimum latency: request seen in IDLE cycle N, mem_req in cycle N+1, mem_ack in N+1, ack in cycle N+2; the next grant is no earlier than N+3.
REQ-029 Requesters deassert req, or present a new request, on the clock edge that ends the ack cycle; IDLE samples the updated inputs.
REQ-030 Input changes on a core's port while its request is in BUSY or RESP have no effect on the operation in flight.
REQ-031 mem_req is 0 in IDLE and RESP; at most one memory operation is outstanding.

Reset
REQ-032 While reset_n=0 at a rising edge: state becomes IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ack0=ack1=0, rdata=0, lock_held=0, lock_owner=0, and the round-robin pointer selects core 0 next.
REQ-033 Reset asserted during BUSY or RESP abandons the operation: no ack is issued, no lock update occurs, and mem_req drops on that edge.

Verification
REQ-034 Single load: req0=1, op0=00, addr0=0x00010, mem_ack one cycle after mem_req with mem_rdata=0xDEADBEEF -> one ack0 pulse with rdata=0xDEADBEEF; lock_held stays 0.
REQ-035 Contention: req0 and req1 both assert stores in the same cycle after reset -> core 0 is served first, then core 1; mem_addr order is addr0 then addr1; one ack each.
REQ-036 Lock exclusion: core 1 load-lock completes (lock_held=1, lock_owner=1); core 0 then issues a load-lock -> no grant to core 0 while core 1 plain loads are still served; core 1 store-unlock -> lock_held=0, then core 0 acquires (lock_owner=0).
REQ-037 Zero-wait memory: mem_ack tied high -> ack at cycle N+2 for a request first seen in cycle N; back-to-back requests from core 0 are served every 3 cycles.
REQ-038 Reset mid-operation: reset_n=0 while in BUSY for a load-lock -> mem_req=0 and lock_held=0 after the edge, and no ack is issued.
REQ-039 Stalled memory: mem_ack is held low for 10 cycles -> mem_req and mem_addr stay stable throughout, and a new req1 is not granted until the current operation's ack completes.
